// File: rtl/rename_sched_pkg.sv
// rename_sched_pkg: shared constants, FSM state encoding and a small helper
// for the rename-stage scheduler.
package rename_sched_pkg;

  localparam int INSTR_WIDTH = 32;
  localparam int C_SIG_WIDTH = 7;
  localparam int PREG_WIDTH  = 6;
  localparam int NUM_FREE    = 32;
  localparam int ROB_DEPTH   = 16;
  localparam int CNT_WIDTH   = 6;

  // Bit of the control-signal bundle that marks a destination-register write.
  localparam int REG_WRITE = 0;

  typedef enum logic [1:0] {
    RS_INIT    = 2'd0,
    RS_RUN     = 2'd1,
    RS_STALL   = 2'd2,
    RS_RECOVER = 2'd3
  } rs_state_e;

  // A new physical register is needed only for a real write; x0 is never renamed.
  function automatic logic needs_alloc(input logic reg_write, input logic [4:0] rd);
    return reg_write && (rd != 5'd0);
  endfunction

endpackage

// File: rtl/rename_sched_if.sv
// rename_sched_if: decode, rename, free-pool, retire and recovery signals of
// the rename-stage scheduler. The slave modport is the scheduler itself; the
// master modport is the surrounding pipeline.
// Optional statistics outputs exist when RENAME_SCHED_STATS_EN is defined.
interface rename_sched_if;
  import rename_sched_pkg::*;

  logic                   dec_valid;
  logic [INSTR_WIDTH-1:0] dec_instr;
  logic [C_SIG_WIDTH-1:0] dec_c_sig;
  logic                   dec_ready;

  logic                   ren_valid;
  logic                   ren_ready;
  logic [INSTR_WIDTH-1:0] ren_instr;
  logic [C_SIG_WIDTH-1:0] ren_c_sig;

  logic                   pool_pop;
  logic                   pool_push;
  logic [PREG_WIDTH-1:0]  pool_freed;

  logic                   retire_valid;
  logic                   retire_free;
  logic [PREG_WIDTH-1:0]  retire_preg;

  logic                   flush;
  logic                   restore_done;
  logic [PREG_WIDTH-1:0]  restore_cnt;

  logic                   stall_free;
  logic                   stall_rob;

`ifdef RENAME_SCHED_STATS_EN
  logic [31:0]            stat_free_stalls;
  logic [31:0]            stat_rob_stalls;
`endif

  modport slave (
    input  dec_valid, dec_instr, dec_c_sig, ren_ready,
           retire_valid, retire_free, retire_preg,
           flush, restore_done, restore_cnt,
    output dec_ready, ren_valid, ren_instr, ren_c_sig,
           pool_pop, pool_push, pool_freed, stall_free, stall_rob
`ifdef RENAME_SCHED_STATS_EN
  , output stat_free_stalls, stat_rob_stalls
`endif
  );

  modport master (
    output dec_valid, dec_instr, dec_c_sig, ren_ready,
           retire_valid, retire_free, retire_preg,
           flush, restore_done, restore_cnt,
    input  dec_ready, ren_valid, ren_instr, ren_c_sig,
           pool_pop, pool_push, pool_freed, stall_free, stall_rob
`ifdef RENAME_SCHED_STATS_EN
  , input  stat_free_stalls, stat_rob_stalls
`endif
  );

endinterface

// File: rtl/rename_sched_credit_ctr.sv
// rename_credit_ctr: saturating up/down credit counter with parallel load.
// Simultaneous inc and dec cancel; the count never wraps below 0 or above MAX_VAL.
// cnt_d_o exposes the next value so the owner can react in the same cycle.
module rename_credit_ctr #(
  parameter int WIDTH     = 6,
  parameter int MAX_VAL   = 32,
  parameter int RESET_VAL = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc_i,
  input  logic             dec_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  output logic [WIDTH-1:0] cnt_o,
  output logic [WIDTH-1:0] cnt_d_o
);

  localparam logic [WIDTH-1:0] MAX_CNT   = WIDTH'(MAX_VAL);
  localparam logic [WIDTH-1:0] RESET_CNT = WIDTH'(RESET_VAL);

  logic [WIDTH-1:0] cnt_q, cnt_d;

  // Next count: load wins, otherwise a saturating single step.
  always_comb begin
    // NOTE: cnt_d gets a default first so every path assigns it and no latch is inferred.
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = (load_val_i > MAX_CNT) ? MAX_CNT : load_val_i;
    end else if (inc_i && !dec_i && cnt_q < MAX_CNT) begin
      cnt_d = cnt_q + WIDTH'(1);
    end else if (dec_i && !inc_i && cnt_q != '0) begin
      cnt_d = cnt_q - WIDTH'(1);
    end
  end

  // Count register, asynchronously returned to its reset value.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: non-blocking assignment so every register samples pre-edge values.
    if (rst) cnt_q <= RESET_CNT;
    else     cnt_q <= cnt_d;
  end

  assign cnt_o   = cnt_q;
  assign cnt_d_o = cnt_d;

endmodule

// File: rtl/rename_sched.sv
// rename_sched: rename-stage scheduler between decode and the rename block.
// Gates decode->rename with valid/ready, tracks free-preg and ROB credits,
// drives free-pool pop/push and sequences flush recovery.
// Defining RENAME_SCHED_STATS_EN adds cycle counters for the two stall reasons.
module rename_sched
  import rename_sched_pkg::*;
(
  input logic            clk,
  input logic            rst,
  rename_sched_if.slave  bus
);

  rs_state_e state_q, state_d;

  logic [CNT_WIDTH-1:0]   free_cnt, free_cnt_nxt;
  logic [CNT_WIDTH-1:0]   rob_cnt, rob_cnt_nxt;

  logic                   ren_valid_q, ren_valid_d;
  logic [INSTR_WIDTH-1:0] ren_instr_q, ren_instr_d;
  logic [C_SIG_WIDTH-1:0] ren_c_sig_q, ren_c_sig_d;

  logic in_recover, slot_free, dec_ready, fire;
  logic pop, push, retire_cnt, restore_load;

  assign in_recover = (state_q == RS_RECOVER);
  assign slot_free  = !ren_valid_q || bus.ren_ready;
  // Readiness deliberately ignores dec_valid and the instruction itself.
  assign dec_ready  = (state_q == RS_RUN) && slot_free && (free_cnt != '0) && (rob_cnt != '0);
  // A flush kills any transfer or allocation that would happen in its cycle.
  assign fire       = bus.dec_valid && dec_ready && !bus.flush;
  assign pop        = ren_valid_q && bus.ren_ready && !bus.flush && !in_recover &&
                      needs_alloc(ren_c_sig_q[REG_WRITE], ren_instr_q[11:7]);
  // Retire traffic is meaningless while the pool/map are being restored.
  assign push         = bus.retire_valid && bus.retire_free && !in_recover;
  assign retire_cnt   = bus.retire_valid && !in_recover;
  assign restore_load = in_recover && bus.restore_done && !bus.flush;

  rename_credit_ctr #(
    .WIDTH    (CNT_WIDTH),
    .MAX_VAL  (NUM_FREE),
    .RESET_VAL(NUM_FREE)
  ) u_free_ctr (
    .clk       (clk),
    .rst       (rst),
    .inc_i     (push),
    .dec_i     (pop),
    .load_i    (restore_load),
    .load_val_i(bus.restore_cnt),
    .cnt_o     (free_cnt),
    .cnt_d_o   (free_cnt_nxt)
  );

  rename_credit_ctr #(
    .WIDTH    (CNT_WIDTH),
    .MAX_VAL  (ROB_DEPTH),
    .RESET_VAL(ROB_DEPTH)
  ) u_rob_ctr (
    .clk       (clk),
    .rst       (rst),
    .inc_i     (retire_cnt),
    .dec_i     (fire),
    .load_i    (bus.flush),
    .load_val_i(CNT_WIDTH'(ROB_DEPTH)),
    .cnt_o     (rob_cnt),
    .cnt_d_o   (rob_cnt_nxt)
  );

  // Next state; a flush overrides every other transition.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RS_INIT:    state_d = RS_RUN;
      RS_RUN:     if (bus.dec_valid && (free_cnt == '0 || rob_cnt == '0)) state_d = RS_STALL;
      // Leave STALL on the credit that arrives this cycle, so decode resumes next cycle.
      RS_STALL:   if (free_cnt_nxt != '0 && rob_cnt_nxt != '0) state_d = RS_RUN;
      RS_RECOVER: if (bus.restore_done) state_d = RS_RUN;
      default:    state_d = RS_INIT;
    endcase
    if (bus.flush) state_d = RS_RECOVER;
  end

  // Output-register next value: flush clears, fire loads, a bare consume empties.
  always_comb begin
    ren_valid_d = ren_valid_q;
    ren_instr_d = ren_instr_q;
    ren_c_sig_d = ren_c_sig_q;
    if (bus.flush) begin
      ren_valid_d = 1'b0;
    end else if (fire) begin
      ren_valid_d = 1'b1;
      ren_instr_d = bus.dec_instr;
      ren_c_sig_d = bus.dec_c_sig;
    end else if (bus.ren_ready) begin
      ren_valid_d = 1'b0;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= RS_INIT;
      ren_valid_q <= 1'b0;
      ren_instr_q <= '0;
      ren_c_sig_q <= '0;
    end else begin
      state_q     <= state_d;
      ren_valid_q <= ren_valid_d;
      ren_instr_q <= ren_instr_d;
      ren_c_sig_q <= ren_c_sig_d;
    end
  end

  assign bus.dec_ready  = dec_ready;
  assign bus.ren_valid  = ren_valid_q;
  assign bus.ren_instr  = ren_instr_q;
  assign bus.ren_c_sig  = ren_c_sig_q;
  assign bus.pool_pop   = pop;
  assign bus.pool_push  = push;
  assign bus.pool_freed = push ? bus.retire_preg : '0;
  assign bus.stall_free = (state_q == RS_STALL) && (free_cnt == '0);
  assign bus.stall_rob  = (state_q == RS_STALL) && (rob_cnt == '0);

`ifdef RENAME_SCHED_STATS_EN
  logic [31:0] stat_free_q, stat_rob_q;

  // Stall-cycle counters; they wrap naturally at 2^32.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_free_q <= '0;
      stat_rob_q  <= '0;
    end else begin
      if (bus.stall_free) stat_free_q <= stat_free_q + 32'd1;
      if (bus.stall_rob)  stat_rob_q  <= stat_rob_q + 32'd1;
    end
  end

  assign bus.stat_free_stalls = stat_free_q;
  assign bus.stat_rob_stalls  = stat_rob_q;
`else
  // Statistics counters are not built in this configuration.
`endif

endmodule
